// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state type and nibble width for the nibble-serial CLA adder
package cla_seq_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    localparam int NIB_W = 4;
endpackage

// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead adder stage
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g, p;
    logic [3:1] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum = p ^ {c, cin};
endmodule

// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: WIDTH-bit adder that feeds one nibble per cycle through a single cla_4bit
// Optional signed-overflow output out_ovf is enabled by defining CLA_NIBBLE_SEQ_OVF_EN.
module cla_nibble_seq
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);
    localparam int NIB = WIDTH / NIB_W;
    localparam int CNT_W = NIB > 1 ? $clog2(NIB) : 1;

    if (WIDTH < NIB_W || WIDTH % NIB_W != 0) begin : g_bad_width
        $error("cla_nibble_seq: WIDTH must be a positive multiple of 4");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a, op_b;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;
    logic             last;

    assign last     = cnt == CNT_W'(NIB - 1);
    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign out_cout = carry;

    cla_4bit u_cla (
        .a   (op_a[NIB_W*cnt +: NIB_W]),
        .b   (op_b[NIB_W*cnt +: NIB_W]),
        .cin (carry),
        .sum (nib_sum),
        .cout(nib_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    op_a  <= in_a;
                    op_b  <= in_b;
                    carry <= in_cin;
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    out_sum[NIB_W*cnt +: NIB_W] <= nib_sum;
                    carry <= nib_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
                        // top nibble's MSB is the final sum sign bit
                        out_ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (nib_sum[NIB_W-1] != op_a[WIDTH-1]);
`endif
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
                    out_ovf   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_seq.sv
// tb_cla_nibble_seq: directed self-checking bench for cla_nibble_seq at WIDTH=16
module tb_cla_nibble_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    logic        out_ovf;
`endif
    int checks = 0;
    int failures = 0;

    cla_nibble_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
`ifdef CLA_NIBBLE_SEQ_OVF_EN
        .out_ovf  (out_ovf),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_result(input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 4);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic [15:0] es, input logic ec, input logic eo);
        in_a = a; in_b = b; in_cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~ci;
        wait_result(tag);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, out_cout, ec);
`ifdef CLA_NIBBLE_SEQ_OVF_EN
        check({tag, "_ovf"}, out_ovf, eo);
`else
        if (eo === 1'bz) $display("unreachable");
`endif
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, "_rel"}, {out_valid, in_ready}, 2'b01);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        @(posedge clk); #1;

        run_op("basic", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("ripple2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("nocarry", 16'hABCD, 16'h5432, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        run_op("negneg", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
`ifdef CLA_NIBBLE_SEQ_OVF_EN
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
`endif

        out_ready = 1'b0;
        run_op("bp", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {in_ready, out_valid, out_cout, out_sum}, {1'b0, 1'b1, 1'b0, 16'h1000});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel", {out_valid, in_ready, busy}, 3'b010);

        in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 16'h7777; in_b = 16'h0889;
        check("hold_rdy", in_ready, 0);
        wait_result("hold1");
        check("hold1_sum", out_sum, 16'h3333);
        @(posedge clk); #1;
        check("hold_idle", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_acc", busy, 1);
        wait_result("hold2");
        check("hold2_sum", out_sum, 16'h8000);
        check("hold2_cout", out_cout, 0);
        @(posedge clk); #1;

        in_a = 16'h4444; in_b = 16'h4444; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid", {out_valid, busy, in_ready}, 3'b001);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_abort", {out_valid, busy, out_sum}, 18'h0);
        run_op("post_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
